// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath
// (IF -> ID -> EX -> [MEM] -> [WB]).
//
// Parameter: WAIT_MAX - request cycles allowed on mem_ready_i in IF/MEM
//   before the request is dropped and timeout_o is set. The cycle whose
//   wait count equals WAIT_MAX may still complete.
// Build option: define MULTICYCLE_CTRL_BRANCH_EN to support BEQ (000100).
//   Without it, BEQ decodes as illegal and zero_i is unused.
//
// Ports:
//   clk_i, rst_n            clock, async active-low reset
//   run_i                   fetch enable, sampled in IF only
//   opcode_i                opcode, valid in ID
//   zero_i                  ALU zero flag, valid in EX
//   mem_ready_i             memory completion strobe
//   instr_req_o             instruction fetch request
//   data_req_o, data_we_o   data memory request / write enable
//   ir_write_o, pc_write_o, reg_write_o   one-cycle write strobes
//   alu_op_o                ALUOp (R 010, ADDI 011, LW/SW 000, BEQ 001)
//   alu_src_o, reg_dst_o, mem_to_reg_o    datapath mux selects
//   instr_done_o            retirement pulse
//   illegal_o, timeout_o    sticky error flags
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       instr_req_o,
  output logic       data_req_o,
  output logic       data_we_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       timeout_o
);

  localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  state_t        r_state;
  logic [5:0]    r_opcode;
  logic [CW-1:0] r_wait;
  logic          r_instr_req;
  logic          r_illegal;
  logic          r_timeout;

  logic w_legal_id;
  logic w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq;
  logic w_in_ex, w_in_mem, w_in_wb, w_post_id;
  logic w_fetch_done;

  always_comb begin
    w_legal_id = 1'b0;
    case (opcode_i)
      OP_R, OP_ADDI, OP_LW, OP_SW: w_legal_id = 1'b1;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
      OP_BEQ:                      w_legal_id = 1'b1;
`endif
      default:                     w_legal_id = 1'b0;
    endcase
  end

  assign w_is_r    = (r_opcode == OP_R);
  assign w_is_addi = (r_opcode == OP_ADDI);
  assign w_is_lw   = (r_opcode == OP_LW);
  assign w_is_sw   = (r_opcode == OP_SW);
`ifdef MULTICYCLE_CTRL_BRANCH_EN
  assign w_is_beq  = (r_opcode == OP_BEQ);
`else
  logic w_unused_zero;
  assign w_unused_zero = zero_i;
  assign w_is_beq  = 1'b0;
`endif

  assign w_in_ex   = (r_state == S_EX);
  assign w_in_mem  = (r_state == S_MEM);
  assign w_in_wb   = (r_state == S_WB);
  assign w_post_id = w_in_ex | w_in_mem | w_in_wb;
  // mem_ready_i only completes a fetch that has actually been issued
  assign w_fetch_done = (r_state == S_IF) & r_instr_req & mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IF;
      r_opcode    <= '0;
      r_wait      <= '0;
      r_instr_req <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IF: begin
          if (r_instr_req) begin
            // an issued request is held regardless of run_i
            if (mem_ready_i) begin
              r_instr_req <= 1'b0;
              r_wait      <= '0;
              r_state     <= S_ID;
            end else if (r_wait == WAIT_LIM) begin
              r_instr_req <= 1'b0;
              r_timeout   <= 1'b1;
              r_wait      <= '0;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end else if (run_i) begin
            r_instr_req <= 1'b1;
          end
        end
        S_ID: begin
          r_opcode <= opcode_i;
          r_wait   <= '0;
          if (w_legal_id) begin
            r_state <= S_EX;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_IF;
          end
        end
        S_EX: begin
          r_wait <= '0;
          if (w_is_r || w_is_addi)     r_state <= S_WB;
          else if (w_is_lw || w_is_sw) r_state <= S_MEM;
          else                         r_state <= S_IF;
        end
        S_MEM: begin
          if (mem_ready_i) begin
            r_wait  <= '0;
            r_state <= w_is_sw ? S_IF : S_WB;
          end else if (r_wait == WAIT_LIM) begin
            r_timeout <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_IF;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB:    r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

  // Outputs decode from registered state and latched opcode; the strobes
  // that must answer mem_ready_i/zero_i in the same cycle are gated by
  // registered terms, so everything is 0 while reset is held.
  always_comb begin
    instr_req_o  = (r_state == S_IF) & r_instr_req;
    ir_write_o   = w_fetch_done;
    pc_write_o   = w_fetch_done | (w_in_ex & w_is_beq & zero_i);
    data_req_o   = w_in_mem;
    data_we_o    = w_in_mem & w_is_sw;
    reg_write_o  = w_in_wb;
    mem_to_reg_o = w_in_wb & w_is_lw;
    alu_src_o    = w_post_id & (w_is_addi | w_is_lw | w_is_sw);
    reg_dst_o    = w_post_id & w_is_r;
    instr_done_o = w_in_wb
                 | ((r_state == S_ID) & ~w_legal_id)
                 | (w_in_ex & w_is_beq)
                 | (w_in_mem & mem_ready_i & w_is_sw);
    alu_op_o = 3'b000;
    if (w_in_ex) begin
      if (w_is_r)         alu_op_o = 3'b010;
      else if (w_is_addi) alu_op_o = 3'b011;
      else if (w_is_beq)  alu_op_o = 3'b001;
      else                alu_op_o = 3'b000;
    end
    illegal_o = r_illegal;
    timeout_o = r_timeout;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Instructions are modelled as transactions
// (fetch latency, opcode, memory latency, zero flag); the expected output
// trace of each is derived from the instruction-class rules.
module tb_multicycle_ctrl;

  localparam int unsigned WAIT_MAX = 15;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
  localparam bit BRANCH = 1'b1;
`else
  localparam bit BRANCH = 1'b0;
`endif

  logic       clk_i, rst_n, run_i, zero_i, mem_ready_i;
  logic [5:0] opcode_i;
  logic       instr_req_o, data_req_o, data_we_o, ir_write_o, pc_write_o;
  logic       reg_write_o, alu_src_o, reg_dst_o, mem_to_reg_o, instr_done_o;
  logic       illegal_o, timeout_o;
  logic [2:0] alu_op_o;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .run_i(run_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .instr_req_o(instr_req_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // {instr_req,data_req,data_we,ir_write,pc_write,reg_write,alu_op,
  //  alu_src,reg_dst,mem_to_reg,instr_done,illegal,timeout}
  logic [14:0] w_obs;
  assign w_obs = {instr_req_o, data_req_o, data_we_o, ir_write_o, pc_write_o,
                  reg_write_o, alu_op_o, alu_src_o, reg_dst_o, mem_to_reg_o,
                  instr_done_o, illegal_o, timeout_o};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        m_ill = 1'b0;
  logic        m_to  = 1'b0;

  function automatic logic [14:0] ev(input logic ireq, dreq, dwe, irw, pcw, rw,
                                     input logic [2:0] aop,
                                     input logic asrc, rdst, m2r, done);
    return {ireq, dreq, dwe, irw, pcw, rw, aop, asrc, rdst, m2r, done, m_ill, m_to};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    n_checks++;
    assert (w_obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
  endtask

  task automatic step(input string tag, input logic run, input logic [5:0] op,
                      input logic z, input logic rdy, input logic [14:0] exp);
    @(negedge clk_i);
    run_i = run; opcode_i = op; zero_i = z; mem_ready_i = rdy;
    #1;
    check(tag, exp);
  endtask

  // One instruction from IF (no request outstanding) back to IF.
  // fd/md: request cycle on which mem_ready_i arrives (> WAIT_MAX = never).
  task automatic do_instr(input logic [5:0] op, input int unsigned fd,
                          input int unsigned md, input logic z);
    int unsigned idle;
    logic legal, is_r, is_addi, is_lw, is_sw, is_beq, asrc;
    logic [2:0] aop;
    is_r    = (op == OP_R);
    is_addi = (op == OP_ADDI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ) && BRANCH;
    legal   = is_r | is_addi | is_lw | is_sw | is_beq;
    asrc    = is_addi | is_lw | is_sw;
    aop     = is_r ? 3'b010 : is_addi ? 3'b011 : is_beq ? 3'b001 : 3'b000;

    idle = $urandom_range(0, 2);
    for (int unsigned i = 0; i < idle; i++)
      step("idle", 1'b0, 6'($urandom), 1'($urandom), 1'b0,
           ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("issue", 1'b1, 6'($urandom), 1'($urandom), 1'b0,
         ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    for (int unsigned k = 0; k <= WAIT_MAX; k++) begin
      if (k == fd) begin
        step("fetch_done", 1'($urandom), 6'($urandom), 1'($urandom), 1'b1,
             ev(1,0,0,1,1,0,3'b000,0,0,0,0));
        break;
      end
      step("fetch_wait", 1'($urandom), 6'($urandom), 1'($urandom), 1'b0,
           ev(1,0,0,0,0,0,3'b000,0,0,0,0));
    end
    if (fd > WAIT_MAX) begin
      m_to = 1'b1;
      step("fetch_timeout", 1'b0, 6'($urandom), 1'($urandom), 1'b0,
           ev(0,0,0,0,0,0,3'b000,0,0,0,0));
      return;
    end

    step("id", 1'($urandom), op, 1'($urandom), 1'($urandom),
         ev(0,0,0,0,0,0,3'b000,0,0,0,!legal));
    if (!legal) begin
      m_ill = 1'b1;
      return;
    end

    step("ex", 1'($urandom), 6'($urandom), z, 1'($urandom),
         ev(0,0,0,0,is_beq & z,0,aop,asrc,is_r,0,is_beq));
    if (is_beq) return;

    if (is_lw || is_sw) begin
      for (int unsigned k = 0; k <= WAIT_MAX; k++) begin
        if (k == md) begin
          step("mem_done", 1'($urandom), 6'($urandom), 1'($urandom), 1'b1,
               ev(0,1,is_sw,0,0,0,3'b000,1,0,0,is_sw));
          break;
        end
        step("mem_wait", 1'($urandom), 6'($urandom), 1'($urandom), 1'b0,
             ev(0,1,is_sw,0,0,0,3'b000,1,0,0,0));
      end
      if (md > WAIT_MAX) begin
        m_to = 1'b1;
        return;
      end
      if (is_sw) return;
    end

    step("wb", 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
         ev(0,0,0,0,0,1,3'b000,asrc,is_r,is_lw,1));
  endtask

  function automatic int unsigned rand_lat();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return r % 3;
    else if (r == 7) return WAIT_MAX;
    else if (r == 8) return WAIT_MAX + 1;
    else             return $urandom_range(3, 6);
  endfunction

  logic [5:0] op_tab [7];

  initial begin
    op_tab[0] = OP_R;   op_tab[1] = OP_ADDI; op_tab[2] = OP_LW;
    op_tab[3] = OP_SW;  op_tab[4] = OP_BEQ;  op_tab[5] = 6'b111111;
    op_tab[6] = 6'b010101;

    rst_n = 1'b0; run_i = 1'b1; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    check("reset_state", ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("reset_hold", 1'b1, 6'($urandom), 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("reset_hold", 1'b1, 6'($urandom), 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    @(negedge clk_i);
    rst_n = 1'b1; run_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    check("reset_release", ev(0,0,0,0,0,0,3'b000,0,0,0,0));

    do_instr(OP_R,    0, 0, 1'b0);
    do_instr(OP_LW,   1, 3, 1'b0);
    do_instr(OP_SW,   0, 0, 1'b0);
    do_instr(OP_BEQ,  0, 0, 1'b1);
    do_instr(OP_BEQ,  2, 0, 1'b0);
    do_instr(OP_ADDI, WAIT_MAX, 0, 1'b0);
    do_instr(OP_LW,   0, WAIT_MAX, 1'b0);
    do_instr(6'b111111, 0, 0, 1'b0);
    do_instr(OP_R,    0, 0, 1'b0);
    do_instr(OP_R,    WAIT_MAX + 1, 0, 1'b0);
    do_instr(OP_SW,   0, WAIT_MAX + 1, 1'b0);

    // asynchronous reset in the middle of an SW memory access
    step("rs_issue", 1'b1, 6'($urandom), 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("rs_fetch", 1'b0, 6'($urandom), 1'b0, 1'b1, ev(1,0,0,1,1,0,3'b000,0,0,0,0));
    step("rs_id",    1'b0, OP_SW,        1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("rs_ex",    1'b0, 6'($urandom), 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,1,0,0,0));
    step("rs_mem",   1'b0, 6'($urandom), 1'b0, 1'b0, ev(0,1,1,0,0,0,3'b000,1,0,0,0));
    #2 rst_n = 1'b0;
    #1;
    m_ill = 1'b0; m_to = 1'b0;
    check("rst_async", ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    step("rst_mid_hold", 1'b1, 6'($urandom), 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    @(negedge clk_i);
    rst_n = 1'b1; run_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    check("rst_mid_release", ev(0,0,0,0,0,0,3'b000,0,0,0,0));
    do_instr(OP_SW, 0, 1, 1'b0);

    for (int i = 0; i < 40; i++)
      do_instr(($urandom_range(0, 7) == 7) ? 6'($urandom) : op_tab[$urandom_range(0, 6)],
               rand_lat(), rand_lat(), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
